mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port memory between the instruction-fetch path and the
//   load/store data path of the RISC-V core. Data accesses win by default; a
//   starvation counter guarantees fetch progress. One transaction outstanding.
//   A watchdog returns an error if memory never responds. Busy drives the core stall.
// PARAMETERS
//   AW            32  address width (byte address, passed through unmodified)
//   DW            32  data width; byte-enable width is DW/8
//   STARVE_LIMIT  4   consecutive data wins over a pending fetch before fetch is forced (1..15)
//   TIMEOUT       64  max WAIT cycles without mem_rvalid before error response (>=2)
// PORTS
//   clk         in   1     clock, rising edge
//   rst_n       in   1     asynchronous reset, active low
//   if_req      in   1     fetch read request (held until if_gnt)
//   if_addr     in   AW    fetch address
//   if_gnt      out  1     fetch request accepted this cycle
//   if_rvalid   out  1     fetch response pulse (one cycle)
//   if_rdata    out  DW    fetch read data, valid with if_rvalid
//   d_req       in   1     data request (held until d_gnt)
//   d_we        in   1     1 = store, 0 = load
//   d_addr      in   AW    data address
//   d_wdata     in   DW    store data
//   d_be        in   DW/8  store byte enables
//   d_gnt       out  1     data request accepted this cycle
//   d_rvalid    out  1     data response pulse (loads and stores)
//   d_rdata     out  DW    load data, valid with d_rvalid (0 for stores)
//   rsp_err     out  1     with x_rvalid: transaction timed out, rdata = 0
//   mem_req     out  1     memory request strobe (one cycle per transaction)
//   mem_we      out  1     memory write enable
//   mem_addr    out  AW    memory address
//   mem_wdata   out  DW    memory write data
//   mem_be      out  DW/8  memory byte enables
//   mem_rvalid  in   1     memory completion (reads and writes), >=1 cycle after mem_req
//   mem_rdata   in   DW    memory read data, valid with mem_rvalid
//   busy        out  1     high whenever state != IDLE
// BEHAVIOUR
//   Reset: state IDLE, starve_cnt 0, owner 0, all outputs and registered mem_* fields 0.
//   FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   IDLE: gnt is combinational; at most one gnt per cycle.
//     Arbitration (only d_req: data; only if_req: fetch).
//     Both requesting: data wins unless starve_cnt == STARVE_LIMIT, then fetch.
//     On gnt: latch owner, we (0 for fetch), addr, wdata, be; go to REQ.
//     starve_cnt: +1 on data gnt while if_req high; cleared on fetch gnt; saturates.
//   REQ: mem_req=1 with latched fields, exactly one cycle; -> WAIT, wdog cleared.
//   WAIT: mem_* fields held, mem_req=0; wdog increments each cycle.
//     mem_rvalid=1: capture mem_rdata (forced 0 if store), err=0; -> RESP.
//     wdog == TIMEOUT-1 with no mem_rvalid: rdata=0, err=1; -> RESP.
//     mem_rvalid and timeout in the same cycle: mem_rvalid wins, err=0.
//   RESP: owner's x_rvalid=1 for one cycle with registered rdata, rsp_err = err; -> IDLE.
//     The other requester's rvalid stays 0.
//   mem_rvalid outside WAIT (late or spurious, including after timeout) is ignored.
//   Latency: gnt in cycle N; mem_req in N+1; rvalid = mem_rvalid cycle + 1.
//   Minimum 4 cycles per transaction. Next gnt is possible in the cycle after RESP.
//   x_rdata holds its value until the next response to that requester.
//   Reset mid-transaction: aborts immediately with no rvalid; the aborted
//   requester must re-request.
// TESTING
//   1 Fetch-only read @0x100: mem_rvalid 2 cycles after mem_req, rdata 0xDEADBEEF
//     -> if_gnt N, mem_req N+1, if_rvalid N+4, if_rdata=0xDEADBEEF.
//   2 Store d_addr=0x40, wdata=0x12345678, be=4'b0011
//     -> mem_we=1, mem_be=0011 for one cycle; d_rvalid=1, d_rdata=0.
//   3 if_req and d_req held continuously, STARVE_LIMIT=4
//     -> grant order D,D,D,D,F,D,D,D,D,F...
//   4 Memory never responds, TIMEOUT=8 -> owner rvalid=1 with rsp_err=1, rdata=0,
//     busy low one cycle later; mem_rvalid injected afterwards is ignored.
//   5 Assert rst_n=0 during WAIT -> all outputs 0 asynchronously; no rvalid;
//     next request is served normally.
//   6 mem_rvalid on the timeout cycle -> rsp_err=0 and the memory data is returned.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the instruction-fetch port and the
//   load/store data port. Data accesses win arbitration by default; a
//   starvation counter forces a fetch grant after STARVE_LIMIT consecutive data
//   wins over a pending fetch. Only one transaction is outstanding at a time.
//   A watchdog ends a transaction with an error response if memory never
//   answers within TIMEOUT wait cycles.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        fetch accept, response pulse, read data
//   d_req/d_we/d_addr/d_wdata/d_be   data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata           data accept, response pulse, load data
//   rsp_err                          with x_rvalid: transaction timed out
//   mem_req/we/addr/wdata/be         memory request strobe and fields
//   mem_rvalid/mem_rdata             memory completion and read data
//   busy                             transaction in flight (core stall)
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            rsp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BW  = DW / 8;
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WDOG_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic            if_gnt_s, d_gnt_s, wait_done_s;
  logic            owner_r;            // 1 = data port, 0 = fetch port
  logic [3:0]      starve_cnt_r;
  logic [WDW-1:0]  wdog_r;
  logic            mem_req_r, mem_we_r;
  logic [AW-1:0]   mem_addr_r;
  logic [DW-1:0]   mem_wdata_r, rsp_data_s;
  logic [BW-1:0]   mem_be_r;
  logic            if_rvalid_r, d_rvalid_r, rsp_err_r;
  logic [DW-1:0]   if_rdata_r, d_rdata_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, arbitration and watchdog-expiry decode.
  always_comb begin
    state_s     = state_r;
    if_gnt_s    = 1'b0;
    d_gnt_s     = 1'b0;
    wait_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Data wins unless a fetch has been starved for STARVE_LIMIT grants.
        if (d_req && !(if_req && (starve_cnt_r == STARVE_MAX))) begin
          d_gnt_s = 1'b1;
        end else if (if_req) begin
          if_gnt_s = 1'b1;
        end else begin
          d_gnt_s = 1'b0;
        end
        if (d_gnt_s || if_gnt_s) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion on the expiry cycle still counts as a completion.
        if (mem_rvalid || (wdog_r == WDOG_LAST)) begin
          wait_done_s = 1'b1;
          state_s     = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Response payload: stores and timeouts return zero data.
  always_comb begin
    rsp_data_s = {DW{1'b0}};
    if (mem_rvalid && !mem_we_r) begin
      rsp_data_s = mem_rdata;
    end else begin
      rsp_data_s = {DW{1'b0}};
    end
  end

  // Request latching, starvation count, watchdog and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= 1'b0;
      starve_cnt_r <= 4'd0;
      wdog_r       <= {WDW{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
      mem_be_r     <= {BW{1'b0}};
      if_rvalid_r  <= 1'b0;
      d_rvalid_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
      if_rdata_r   <= {DW{1'b0}};
      d_rdata_r    <= {DW{1'b0}};
    end else begin
      mem_req_r   <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (d_gnt_s) begin
            owner_r     <= 1'b1;
            mem_req_r   <= 1'b1;
            mem_we_r    <= d_we;
            mem_addr_r  <= d_addr;
            mem_wdata_r <= d_wdata;
            mem_be_r    <= d_be;
            if (if_req && (starve_cnt_r != STARVE_MAX)) begin
              starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else if (if_gnt_s) begin
            owner_r      <= 1'b0;
            mem_req_r    <= 1'b1;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= if_addr;
            mem_wdata_r  <= {DW{1'b0}};
            mem_be_r     <= {BW{1'b0}};
            starve_cnt_r <= 4'd0;
          end else begin
            owner_r <= owner_r;
          end
        end
        ST_REQ: begin
          wdog_r <= {WDW{1'b0}};
        end
        ST_WAIT: begin
          if (wait_done_s) begin
            rsp_err_r <= ~mem_rvalid;
            if (owner_r) begin
              d_rvalid_r <= 1'b1;
              d_rdata_r  <= rsp_data_s;
            end else begin
              if_rvalid_r <= 1'b1;
              if_rdata_r  <= rsp_data_s;
            end
          end else begin
            wdog_r <= wdog_r + {{(WDW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          wdog_r <= wdog_r;
        end
      endcase
    end
  end

  // Grants are combinational; masking with rst_n keeps every output low in reset.
  assign if_gnt    = if_gnt_s & rst_n;
  assign d_gnt     = d_gnt_s & rst_n;
  assign if_rvalid = if_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rvalid  = d_rvalid_r;
  assign d_rdata   = d_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        rsp_err, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #3;
    checks++; if ({busy, mem_req, mem_we, if_rvalid, d_rvalid, rsp_err, if_gnt, d_gnt} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000000", {busy, mem_req, mem_we, if_rvalid, d_rvalid, rsp_err, if_gnt, d_gnt});
    end
    checks++; if ({mem_addr, mem_wdata, mem_be, if_rdata, d_rdata} !== 132'h0) begin
      errors++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, mem_be, if_rdata, d_rdata});
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin errors++; $display("FAIL t1_gnt got=%b exp=10", {if_gnt, d_gnt}); end
    step(); if_req = 1'b0;
    checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL t1_memreq got=%b%b %h exp=10 00000100", mem_req, mem_we, mem_addr);
    end
    step();
    checks++; if ({mem_req, if_rvalid, busy} !== 3'b001) begin errors++; $display("FAIL t1_wait got=%b exp=001", {mem_req, if_rvalid, busy}); end
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    step(); mem_rvalid = 1'b0;
    checks++; if ({if_rvalid, d_rvalid, rsp_err} !== 3'b100) begin errors++; $display("FAIL t1_rvalid got=%b exp=100", {if_rvalid, d_rvalid, rsp_err}); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata got=%h exp=deadbeef", if_rdata); end
    step();
    checks++; if ({if_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL t1_idle got=%b exp=00", {if_rvalid, busy}); end
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; d_be = 4'b0011;
    #1;
    checks++; if ({if_gnt, d_gnt} !== 2'b01) begin errors++; $display("FAIL t2_gnt got=%b exp=01", {if_gnt, d_gnt}); end
    step(); d_req = 1'b0;
    checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h40, 32'h12345678}) begin
      errors++; $display("FAIL t2_memreq got=%b%b%b %h %h exp=110011 00000040 12345678", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t2_req_pulse got=%b exp=0", mem_req); end
    step(); mem_rvalid = 1'b0;
    checks++; if ({d_rvalid, if_rvalid, rsp_err} !== 3'b100) begin errors++; $display("FAIL t2_rvalid got=%b exp=100", {d_rvalid, if_rvalid, rsp_err}); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL t2_rdata got=%h exp=0", d_rdata); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t2_if_hold got=%h exp=deadbeef", if_rdata); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle got=%b exp=0", busy); end
  endtask

  // Both ports request continuously; also covers back-to-back grants.
  task automatic test_starvation();
    logic        exp_d;
    logic [31:0] data;
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      exp_d = ((g % 5) != 4);
      data  = 32'hA0000000 + 32'(g);
      #1;
      checks++; if ({d_gnt, if_gnt} !== {exp_d, ~exp_d}) begin
        errors++; $display("FAIL t3_order_%0d got=%b exp=%b", g, {d_gnt, if_gnt}, {exp_d, ~exp_d});
      end
      step();
      checks++; if (mem_addr !== (exp_d ? 32'h300 : 32'h200)) begin
        errors++; $display("FAIL t3_addr_%0d got=%h exp=%h", g, mem_addr, exp_d ? 32'h300 : 32'h200);
      end
      step(); mem_rvalid = 1'b1; mem_rdata = data;
      step(); mem_rvalid = 1'b0;
      checks++; if ({d_rvalid, if_rvalid} !== {exp_d, ~exp_d}) begin
        errors++; $display("FAIL t3_rvalid_%0d got=%b exp=%b", g, {d_rvalid, if_rvalid}, {exp_d, ~exp_d});
      end
      checks++; if ((exp_d ? d_rdata : if_rdata) !== data) begin
        errors++; $display("FAIL t3_rdata_%0d got=%h exp=%h", g, exp_d ? d_rdata : if_rdata, data);
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL t4_gnt got=%b exp=1", d_gnt); end
    step(); d_req = 1'b0;
    for (int i = 0; i < 8; i++) step();
    checks++; if ({d_rvalid, busy} !== 2'b01) begin errors++; $display("FAIL t4_early got=%b exp=01", {d_rvalid, busy}); end
    step();
    checks++; if ({d_rvalid, rsp_err, if_rvalid} !== 3'b110) begin errors++; $display("FAIL t4_err got=%b exp=110", {d_rvalid, rsp_err, if_rvalid}); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL t4_rdata got=%h exp=0", d_rdata); end
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    checks++; if ({busy, d_rvalid, rsp_err} !== 3'b000) begin errors++; $display("FAIL t4_idle got=%b exp=000", {busy, d_rvalid, rsp_err}); end
    step(); mem_rvalid = 1'b0;
    checks++; if ({busy, d_rvalid, if_rvalid} !== 3'b000) begin errors++; $display("FAIL t4_late got=%b exp=000", {busy, d_rvalid, if_rvalid}); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL t4_late_data got=%h exp=0", d_rdata); end
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h55AA55AA; d_be = 4'hF;
    step(); d_req = 1'b0;
    step(); step();
    checks++; if ({busy, mem_we} !== 2'b11) begin errors++; $display("FAIL t5_inflight got=%b exp=11", {busy, mem_we}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, mem_req, mem_we, if_rvalid, d_rvalid, rsp_err, if_gnt, d_gnt} !== 8'h00) begin
      errors++; $display("FAIL t5_async_ctrl got=%b exp=00000000", {busy, mem_req, mem_we, if_rvalid, d_rvalid, rsp_err, if_gnt, d_gnt});
    end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      errors++; $display("FAIL t5_async_data got=%h exp=0", {mem_addr, mem_wdata, mem_be});
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step(); step();
    mem_rvalid = 1'b0; rst_n = 1'b1;
    step();
    checks++; if ({d_rvalid, if_rvalid, busy} !== 3'b000) begin errors++; $display("FAIL t5_no_rvalid got=%b exp=000", {d_rvalid, if_rvalid, busy}); end
    if_req = 1'b1; if_addr = 32'h600;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL t5_regnt got=%b exp=1", if_gnt); end
    step(); if_req = 1'b0;
    step();
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step(); mem_rvalid = 1'b0;
    checks++; if ({if_rvalid, rsp_err, if_rdata} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL t5_after got=%b%b %h exp=10 cafef00d", if_rvalid, rsp_err, if_rdata);
    end
    step();
  endtask

  task automatic test_timeout_race();
    if_req = 1'b1; if_addr = 32'h700;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL t6_gnt got=%b exp=1", if_gnt); end
    step(); if_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
    step(); mem_rvalid = 1'b0;
    checks++; if ({if_rvalid, rsp_err} !== 2'b10) begin errors++; $display("FAIL t6_rvalid got=%b exp=10", {if_rvalid, rsp_err}); end
    checks++; if (if_rdata !== 32'h13579BDF) begin errors++; $display("FAIL t6_rdata got=%h exp=13579bdf", if_rdata); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_idle got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_timeout_race();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
